lc3_boot_loader: RTL and testbench

- Boot and program-load sequencer for the LC3 core and its 2^ADDR_W x 16 program memory.
- Holds the core in reset while it accepts a word stream (origin, length, payload) over a valid/ready interface and writes the payload into memory.
- Then releases the core and hands the memory port back to the core's MAR/MDR/memwe signals.
- Sits between the core, the memory and the host/UART word source.

---
 rtl/lc3_boot_loader.sv | 181 ++++++++++++++++++
 tb/tb_lc3_boot_loader.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/lc3_boot_loader.sv
// lc3_boot_loader: holds the LC3 core in reset while a word stream
// (origin, length, payload) is written into program memory, then releases
// the core and hands the memory port to the core's MAR/MDR/memwe signals.
module lc3_boot_loader #(
   parameter int ADDR_W     = 8,
   parameter bit AUTO_START = 1'b0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              s_valid,
   input  logic [15:0]       s_data,
   output logic              s_ready,
   input  logic [15:0]       core_mar,
   input  logic [15:0]       core_mdr,
   input  logic              core_memwe,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [15:0]       mem_wdata,
   output logic              mem_we,
   output logic              core_reset,
   output logic              busy,
   output logic              err,
   output logic [15:0]       words_left
);

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_HDR_ORG = 3'd1;
   localparam logic [2:0] ST_HDR_LEN = 3'd2;
   localparam logic [2:0] ST_LOAD    = 3'd3;
   localparam logic [2:0] ST_REL     = 3'd4;
   localparam logic [2:0] ST_RUN     = 3'd5;
   localparam logic [2:0] ST_ERR     = 3'd6;

   // One past the last memory address; a load may end exactly here.
   localparam logic [16:0] DEPTH = 17'd1 << ADDR_W;

   logic [2:0]        state_q, state_d;
   logic [15:0]       origin_q, origin_d;
   logic [ADDR_W-1:0] addr_cnt_q, addr_cnt_d;
   logic [15:0]       words_left_q, words_left_d;
   logic              core_reset_q, core_reset_d;
   logic              err_q, err_d;

   logic              hs_s;
   logic [16:0]       end_s;
   logic              org_high_s;

   // Next-state, header checking and load counters.
   always_comb begin
      state_d      = state_q;
      origin_d     = origin_q;
      addr_cnt_d   = addr_cnt_q;
      words_left_d = words_left_q;
      s_ready      = (state_q == ST_HDR_ORG) || (state_q == ST_HDR_LEN) || (state_q == ST_LOAD);
      hs_s         = s_valid && s_ready;
      end_s        = {1'b0, origin_q} + {1'b0, s_data};
      // Shift rather than slice so ADDR_W=16 still elaborates.
      org_high_s   = (origin_q >> ADDR_W) != 16'd0;
      case (state_q)
         ST_IDLE: begin
            if (start || AUTO_START) begin
               state_d = ST_HDR_ORG;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_HDR_ORG: begin
            if (hs_s) begin
               origin_d = s_data;
               state_d  = ST_HDR_LEN;
            end else begin
               state_d  = ST_HDR_ORG;
            end
         end
         ST_HDR_LEN: begin
            if (hs_s) begin
               if (org_high_s || (end_s > DEPTH)) begin
                  words_left_d = 16'd0;
                  state_d      = ST_ERR;
               end else if (s_data == 16'd0) begin
                  words_left_d = 16'd0;
                  state_d      = ST_REL;
               end else begin
                  words_left_d = s_data;
                  addr_cnt_d   = origin_q[ADDR_W-1:0];
                  state_d      = ST_LOAD;
               end
            end else begin
               state_d = ST_HDR_LEN;
            end
         end
         ST_LOAD: begin
            if (hs_s) begin
               // The counter wraps to 0 after the top address; harmless.
               addr_cnt_d   = addr_cnt_q + {{(ADDR_W-1){1'b0}}, 1'b1};
               words_left_d = words_left_q - 16'd1;
               if (words_left_q == 16'd1) begin
                  state_d = ST_REL;
               end else begin
                  state_d = ST_LOAD;
               end
            end else begin
               state_d = ST_LOAD;
            end
         end
         ST_REL: begin
            state_d = ST_RUN;
         end
         ST_RUN: begin
            if (start) begin
               state_d = ST_HDR_ORG;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_ERR: begin
            if (start) begin
               state_d = ST_HDR_ORG;
            end else begin
               state_d = ST_ERR;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      // Core runs only in RUN; err mirrors the ERR state, both registered.
      core_reset_d = (state_d != ST_RUN);
      err_d        = (state_d == ST_ERR);
   end

   // Memory-port mux: the core owns it only in RUN.
   always_comb begin
      mem_addr  = addr_cnt_q;
      mem_wdata = 16'd0;
      mem_we    = 1'b0;
      case (state_q)
         ST_RUN: begin
            mem_addr  = core_mar[ADDR_W-1:0];
            mem_wdata = core_mdr;
            mem_we    = core_memwe;
         end
         ST_LOAD: begin
            mem_addr  = addr_cnt_q;
            mem_wdata = hs_s ? s_data : 16'd0;
            mem_we    = hs_s;
         end
         default: begin
            mem_addr  = addr_cnt_q;
            mem_wdata = 16'd0;
            mem_we    = 1'b0;
         end
      endcase
   end

   // State and datapath registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= ST_IDLE;
         origin_q     <= 16'd0;
         addr_cnt_q   <= {ADDR_W{1'b0}};
         words_left_q <= 16'd0;
         core_reset_q <= 1'b1;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         origin_q     <= origin_d;
         addr_cnt_q   <= addr_cnt_d;
         words_left_q <= words_left_d;
         core_reset_q <= core_reset_d;
         err_q        <= err_d;
      end
   end

   assign busy       = (state_q == ST_HDR_ORG) || (state_q == ST_HDR_LEN) ||
                       (state_q == ST_LOAD) || (state_q == ST_REL);
   assign err        = err_q;
   assign core_reset = core_reset_q;
   assign words_left = words_left_q;

endmodule

// File: tb/tb_lc3_boot_loader.sv
// Bench for lc3_boot_loader: random program loads scored against a
// queue of expected memory writes, plus direct checks of control outputs.
module tb_lc3_boot_loader;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        s_valid;
   logic [15:0] s_data;
   logic        s_ready;
   logic [15:0] core_mar;
   logic [15:0] core_mdr;
   logic        core_memwe;
   logic [7:0]  mem_addr;
   logic [15:0] mem_wdata;
   logic        mem_we;
   logic        core_reset;
   logic        busy;
   logic        err;
   logic [15:0] words_left;

   // Second instance with AUTO_START=1, otherwise idle.
   logic        a_start, a_valid, a_memwe;
   logic [15:0] a_data, a_mar, a_mdr;
   logic        a_ready, a_we, a_core_reset, a_busy, a_err;
   logic [7:0]  a_addr;
   logic [15:0] a_wdata, a_words_left;

   int          errors = 0;
   int          checks = 0;
   logic [23:0] exp_q[$];
   logic [15:0] fixed_words[$];
   bit          last_run;

   lc3_boot_loader #(.ADDR_W(8), .AUTO_START(1'b0)) dut (
      .clk(clk), .reset(rst_n), .start(start), .s_valid(s_valid), .s_data(s_data),
      .s_ready(s_ready), .core_mar(core_mar), .core_mdr(core_mdr), .core_memwe(core_memwe),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .core_reset(core_reset),
      .busy(busy), .err(err), .words_left(words_left)
   );

   lc3_boot_loader #(.ADDR_W(8), .AUTO_START(1'b1)) u_auto (
      .clk(clk), .reset(rst_n), .start(a_start), .s_valid(a_valid), .s_data(a_data),
      .s_ready(a_ready), .core_mar(a_mar), .core_mdr(a_mdr), .core_memwe(a_memwe),
      .mem_addr(a_addr), .mem_wdata(a_wdata), .mem_we(a_we), .core_reset(a_core_reset),
      .busy(a_busy), .err(a_err), .words_left(a_words_left)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every observed memory write must match the scoreboard head.
   always @(negedge clk) begin
      if (mem_we === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: addr=%0h data=%0h, none expected", mem_addr, mem_wdata);
         end else begin
            logic [23:0] e;
            e = exp_q.pop_front();
            check("mem_write", {8'h00, mem_addr, mem_wdata}, {8'h00, e});
         end
      end
   end

   task automatic wait_cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      wait_cyc();
      start = 1'b0;
   endtask

   // Offer one word and hold it until the loader takes it (bounded).
   task automatic send(input logic [15:0] d);
      int n;
      n = 0;
      s_valid = 1'b1;
      s_data  = d;
      @(negedge clk);
      while (s_ready !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) begin
         check("handshake_timeout", 32'd0, 32'd1);
      end
      wait_cyc();
      s_valid = 1'b0;
   endtask

   task automatic core_write();
      core_mar   = 16'($urandom);
      core_mdr   = 16'($urandom);
      core_memwe = 1'b1;
      exp_q.push_back({core_mar[7:0], core_mdr});
      wait_cyc();
      core_memwe = 1'b0;
   endtask

   // Reference: a load is legal iff it fits entirely below address 256.
   task automatic run_load(input int org, input int len, input int abort_at);
      bit legal;
      logic [15:0] d;
      legal = (org < 256) && (org + len <= 256);
      pulse_start();
      check("busy_hdr", busy, 1);
      check("err_clear", err, 0);
      check("core_reset_hdr", core_reset, 1);
      send(16'(org));
      send(16'(len));
      if (!legal) begin
         check("err_set", err, 1);
         check("core_reset_err", core_reset, 1);
         check("busy_err", busy, 0);
         check("s_ready_err", s_ready, 0);
         last_run = 1'b0;
         return;
      end
      for (int i = 0; i < len; i++) begin
         if (i == abort_at) begin
            core_memwe = 1'b0;
            rst_n = 1'b0;
            #1;
            check("rst_core_reset", core_reset, 1);
            check("rst_words_left", words_left, 0);
            check("rst_busy", busy, 0);
            check("rst_s_ready", s_ready, 0);
            wait_cyc();
            rst_n = 1'b1;
            check("auto_idle", a_busy, 0);
            wait_cyc();
            check("auto_hdr_org", a_busy, 1);
            check("idle_no_auto", busy, 0);
            last_run = 1'b0;
            return;
         end
         // Idle gap: stray start pulses and core writes must be ignored.
         repeat ($urandom_range(0, 2)) begin
            start      = 1'($urandom_range(0, 1));
            core_memwe = 1'b1;
            core_mar   = 16'($urandom);
            core_mdr   = 16'($urandom);
            wait_cyc();
            start = 1'b0;
         end
         check("words_left", words_left, 32'(len - i));
         check("busy_load", busy, 1);
         if (fixed_words.size() > 0) d = fixed_words.pop_front();
         else d = 16'($urandom);
         exp_q.push_back({8'(org + i), d});
         send(d);
      end
      core_memwe = 1'b0;
      check("rel_busy", busy, 1);
      check("rel_core_reset", core_reset, 1);
      check("rel_s_ready", s_ready, 0);
      wait_cyc();
      check("run_core_reset", core_reset, 0);
      check("run_busy", busy, 0);
      check("run_words_left", words_left, 0);
      check("run_err", err, 0);
      last_run = 1'b1;
   endtask

   initial begin
      int sel, org, len;
      rst_n = 1'b0; start = 1'b0; s_valid = 1'b0; s_data = 16'd0;
      core_mar = 16'd0; core_mdr = 16'd0; core_memwe = 1'b0;
      a_start = 1'b0; a_valid = 1'b0; a_data = 16'd0;
      a_mar = 16'd0; a_mdr = 16'd0; a_memwe = 1'b0;
      last_run = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      check("reset_core_reset", core_reset, 1);
      check("reset_busy", busy, 0);
      check("reset_err", err, 0);
      check("reset_s_ready", s_ready, 0);
      check("reset_words_left", words_left, 0);
      check("reset_mem_addr", mem_addr, 0);
      check("reset_mem_we", mem_we, 0);
      check("reset_auto_idle", a_busy, 0);
      wait_cyc();
      check("auto_start", a_busy, 1);
      check("no_auto_start", busy, 0);

      // Directed loads: basic, errors, top boundary, zero length, abort.
      fixed_words.push_back(16'h1021);
      fixed_words.push_back(16'h5020);
      fixed_words.push_back(16'h0FFE);
      run_load(0, 3, -1);
      core_write();
      run_load(16'h00FE, 3, -1);
      run_load(16'h0100, 1, -1);
      run_load(16'h00FD, 3, -1);
      run_load(16'h0040, 0, -1);
      run_load(16'h0010, 5, 2);

      // Randomised loads across legal, boundary and illegal headers.
      for (int it = 0; it < 25; it++) begin
         sel = $urandom_range(0, 5);
         case (sel)
            0, 1: begin org = $urandom_range(0, 248); len = $urandom_range(1, 7); end
            2: begin org = $urandom_range(0, 255); len = 0; end
            3: begin len = $urandom_range(1, 6); org = 256 - len; end
            4: begin len = $urandom_range(2, 6); org = 256 - len + $urandom_range(1, len - 1); end
            default: begin org = $urandom_range(256, 65535); len = $urandom_range(0, 4); end
         endcase
         run_load(org, len, -1);
         if (last_run) core_write();
      end

      wait_cyc();
      check("scoreboard_empty", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
